// File: rtl/tt_um_sowmya_quad_decoder.sv
// Quadrature (A/B) decoder with 8-bit position counter, index clear and sticky error flag.
// Optional A/B glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module tt_um_sowmya_quad_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int DATA_W = 8;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam logic [2:0] FILL = 3'd4;
`else
  localparam logic [2:0] FILL = 3'd2;
`endif

  // Gray-coded {B,A} to a binary phase index: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Returns {wrap, next_position} for a single +1/-1 step.
  function automatic logic [DATA_W:0] step_pos(input logic [DATA_W-1:0] pos, input logic up);
    logic signed [1:0]      delta;
    logic signed [DATA_W:0] sum;
    delta = up ? 2'sb01 : 2'sb11;
    sum   = $signed({1'b0, pos}) + (DATA_W+1)'(delta);
    return sum;
  endfunction

  logic [3:0]        sync_p0, sync_p1;
  logic [1:0]        ab_p1, ab_dec;
  logic              idx_p1, clr_p1;
  logic [1:0]        state_q;
  logic              primed;
  logic [2:0]        fill_cnt;
  logic              idx_q;
  logic [DATA_W-1:0] pos_q;
  logic              dir_q, step_q, wrap_q, err_q;
  logic [1:0]        diff;
  logic              step_up, step_dn, illegal, idx_rise;
  logic [DATA_W:0]   pos_nxt;

  // Stage p0/p1: two-flop synchronizer for {err_clr, index, B, A}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {ui_in[4], ui_in[2], ui_in[1:0]};
      sync_p1 <= sync_p0;
    end
  end

  assign ab_p1  = sync_p1[1:0];
  assign idx_p1 = sync_p1[2];
  assign clr_p1 = sync_p1[3];

`ifdef QDEC_GLITCH_FILTER_EN
  // Filter: output follows the input only once three consecutive samples agree.
  logic [1:0] hist1_q, hist2_q, filt_q;
  logic [1:0] agree;

  always_comb begin
    agree  = ~(ab_p1 ^ hist1_q) & ~(hist1_q ^ hist2_q);
    ab_dec = (agree & ab_p1) | (~agree & filt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= '0;
      hist2_q <= '0;
      filt_q  <= '0;
    end else begin
      hist1_q <= ab_p1;
      hist2_q <= hist1_q;
      filt_q  <= ab_dec;
    end
  end
`else
  assign ab_dec = ab_p1;
`endif

  always_comb begin
    diff     = gray2bin(ab_dec) - gray2bin(state_q);
    step_up  = primed && (diff == 2'd1);
    step_dn  = primed && (diff == 2'd3);
    illegal  = primed && (diff == 2'd2);
    idx_rise = primed && ui_in[3] && idx_p1 && !idx_q;
    pos_nxt  = step_pos(pos_q, step_up);
  end

  // Stage p2: decode, count, flags. Priming waits until the front end carries real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= 2'b00;
      primed   <= 1'b0;
      fill_cnt <= '0;
      idx_q    <= 1'b0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      idx_q  <= idx_p1;
      if (!primed) begin
        if (fill_cnt == FILL) begin
          primed  <= 1'b1;
          state_q <= ab_dec;
        end else begin
          fill_cnt <= fill_cnt + 3'd1;
        end
      end else begin
        state_q <= ab_dec;
        if (idx_rise) begin
          pos_q <= '0;
        end else if (step_up || step_dn) begin
          pos_q  <= pos_nxt[DATA_W-1:0];
          wrap_q <= pos_nxt[DATA_W];
          dir_q  <= step_up;
          step_q <= 1'b1;
        end
      end
      if (clr_p1)
        err_q <= 1'b0;
      else if (illegal)
        err_q <= 1'b1;
    end
  end

  assign uo_out  = pos_q;
  assign uio_out = {4'b0000, wrap_q, err_q, step_q, dir_q};
  assign uio_oe  = 8'b0000_1111;

  logic unused;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:5]};

endmodule

// File: tb/tb_tt_um_sowmya_quad_decoder.sv
// Scoreboard bench for the quadrature decoder: stimulus queues expected output changes,
// a monitor compares each change of {uio_out[3:0], uo_out} against the queue.
module tb_tt_um_sowmya_quad_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_checks = 0;
  int n_pass = 0;
  logic [11:0] exp_q[$];

  tt_um_sowmya_quad_decoder dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .ena(ena)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] ab);
    ui_in[1:0] = ab;
  endtask

  // Expected event pair for a step: pulse cycle, then the pulse falling.
  task automatic push_step(input logic [7:0] pos, input logic dir, input logic wrap);
    exp_q.push_back({wrap, 1'b0, 1'b1, dir, pos});
    exp_q.push_back({1'b0, 1'b0, 1'b0, dir, pos});
  endtask

  task automatic do_reset(input logic [1:0] ab);
    rst_n = 1'b0;
    set_ab(ab);
    tick(3);
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    tick(8);
  endtask

  // Monitor: every change of the visible outputs must match the next queued expectation.
  initial begin
    logic [11:0] prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else begin
        cur = {uio_out[3:0], uo_out};
        if (cur !== prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {20'h0, cur}, {20'h0, prev});
          end else begin
            e = exp_q.pop_front();
            check("event", {20'h0, cur}, {20'h0, e});
          end
          check("uio_out_hi", uio_out[7:4], 4'h0);
          prev = cur;
        end
      end
    end
  end

  initial begin
    logic [1:0] seq [4];
    logic [1:0] seq5 [5];
    seq  = '{2'b01, 2'b11, 2'b10, 2'b00};
    seq5 = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};

    // Forward cycle: four up steps to position 4.
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      push_step(8'(i + 1), 1'b1, 1'b0);
      set_ab(seq[i]);
`ifndef QDEC_GLITCH_FILTER_EN
      if (i == 0) begin
        tick(2);
        check("latency_before_k2", uo_out, 8'd0);
        tick(1);
        check("latency_at_k2", uo_out, 8'd1);
        tick(5);
      end else
        tick(8);
`else
      tick(8);
`endif
    end
    check("fwd_pos", uo_out, 8'd4);
    check("fwd_err", uio_out[2], 1'b0);

    // Reverse step from 0 wraps to 255, then forward step wraps back to 0.
    do_reset(2'b00);
    push_step(8'd255, 1'b0, 1'b1);
    set_ab(2'b10);
    tick(8);
    push_step(8'd0, 1'b1, 1'b1);
    set_ab(2'b00);
    tick(8);

    // Illegal jump sets sticky err; err_clr clears it; counting continues from 11.
    do_reset(2'b00);
    exp_q.push_back({4'b0100, 8'd0});
    set_ab(2'b11);
    tick(8);
    check("err_pos_unchanged", uo_out, 8'd0);
    exp_q.push_back({4'b0000, 8'd0});
    ui_in[4] = 1'b1;
    tick(4);
    ui_in[4] = 1'b0;
    tick(6);
    push_step(8'd1, 1'b1, 1'b0);
    set_ab(2'b10);
    tick(8);

    // Index clear wins over a simultaneous step at position 5.
    do_reset(2'b00);
    ui_in[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_step(8'(i + 1), 1'b1, 1'b0);
      set_ab(seq5[i]);
      tick(8);
    end
    exp_q.push_back({4'b0001, 8'd0});
    ui_in[2:0] = 3'b111;
    tick(8);
    check("index_clear_pos", uo_out, 8'd0);
    check("index_clear_step", uio_out[1], 1'b0);
    ui_in[2] = 1'b0;
    tick(4);
    push_step(8'd1, 1'b1, 1'b0);
    set_ab(2'b10);
    tick(8);
    ui_in[3] = 1'b0;

    // A=B=1 through reset release primes without err or count.
    do_reset(2'b11);
    tick(4);
    check("prime11_pos", uo_out, 8'd0);
    check("prime11_err", uio_out[2], 1'b0);
    push_step(8'd1, 1'b1, 1'b0);
    set_ab(2'b10);
    tick(8);

`ifdef QDEC_GLITCH_FILTER_EN
    // Two-cycle glitch rejected; a held change counts at edge k+4.
    do_reset(2'b00);
    set_ab(2'b01);
    tick(2);
    set_ab(2'b00);
    tick(8);
    check("glitch_rejected", uo_out, 8'd0);
    push_step(8'd1, 1'b1, 1'b0);
    set_ab(2'b01);
    tick(4);
    check("filt_latency_before_k4", uo_out, 8'd0);
    tick(1);
    check("filt_latency_at_k4", uo_out, 8'd1);
    tick(8);
`endif

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_um_sowmya_quad_decoder.md
TT_UM_SOWMYA_QUAD_DECODER -- requirements
Module: tt_um_sowmya_quad_decoder

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ui_in  input  8  [0]=A, [1]=B quadrature phases; [2]=index; [3]=index_en; [4]=err_clr; [7:5] unused.
REQ-005 uo_out  output  8  position counter value.
REQ-006 uio_out  output  8  [0]=dir (1=up), [1]=step pulse, [2]=err (sticky), [3]=wrap pulse, [7:4]=0.
REQ-007 uio_oe  output  8  constant 8'b0000_1111.
REQ-008 uio_in  input  8  unused.
REQ-009 ena  input  1  ignored; the decoder always runs.

Function
REQ-010 A, B, index and err_clr SHALL each pass through a two-flop synchronizer before any use.
REQ-011 The decoded 2-bit state SHALL be {B,A} after synchronization and optional filtering.
REQ-012 The stored state SHALL compare against the new state every cycle.
REQ-013 The up sequence SHALL be 00->01->11->10->00; each single step SHALL add +1 to position and set dir=1.
REQ-014 The reverse sequence SHALL add -1 to position and set dir=0.
REQ-015 If the new state equals the stored state, position and dir SHALL be unchanged and step SHALL be 0.
REQ-016 Any two-bit change (00<->11, 01<->10) SHALL be illegal: position and dir unchanged, err set to 1, step 0.
REQ-017 step SHALL be a one-cycle pulse that is high on the cycle position changes.
REQ-018 position SHALL be 8-bit modulo: 255+1 gives 0, and 0-1 gives 255.
REQ-019 wrap SHALL pulse for one cycle with the step that wraps position.
REQ-020 Latency with the filter excluded SHALL be as follows: an A/B change stable before edge k updates uo_out after edge k+2.
REQ-021 A rising edge of the synchronized index while index_en=1 SHALL clear position to 0 on the cycle after the edge is detected.
REQ-022 In the index-clear cycle, step and wrap SHALL be 0.
REQ-023 The stored quadrature state SHALL still update in the index-clear cycle.
REQ-024 When an index clear and a step occur in the same cycle, the clear SHALL win: position=0.
REQ-025 While the synchronized err_clr=1, err SHALL be 0; err_clr SHALL dominate an illegal transition in the same cycle.
REQ-026 The first decoded sample after reset release SHALL only load the stored state (prime): no count, no err, no step.

Reset
REQ-027 rst_n=0 SHALL asynchronously force all synchronizer and filter flops to 0.
REQ-028 rst_n=0 SHALL asynchronously force stored state=00, primed=0, position=0x00.
REQ-029 rst_n=0 SHALL asynchronously force dir=0, step=0, err=0, wrap=0.
REQ-030 During reset, uo_out SHALL read 0x00 and uio_out SHALL read 0x00.
REQ-031 Reset asserted mid-sequence SHALL discard the in-flight transition; counting SHALL resume from 0 with a fresh prime.

Configuration
REQ-032 When macro QDEC_GLITCH_FILTER_EN is defined, each of A and B SHALL pass a filter after the synchronizer.
REQ-033 The filter output SHALL change only after the synchronized input holds the new value for 3 consecutive clocks.
REQ-034 With the filter, pulses of 1-2 cycles SHALL be rejected, and latency SHALL be edge k+4.
REQ-035 When QDEC_GLITCH_FILTER_EN is undefined, synchronizer outputs SHALL feed the decoder directly at REQ-020 latency.

Verification
REQ-036 Reset with A=B=0, then apply 00->01->11->10->00, holding each state 8 cycles -> uo_out=4, dir=1, four step pulses, err=0.
REQ-037 From position 0, apply one reverse step 00->10 -> uo_out=255, dir=0, wrap pulse high for one cycle.
REQ-038 Jump A/B 00->11 -> err=1 and uo_out unchanged; then assert err_clr for 4 cycles -> err=0.
REQ-039 At position 5, set index_en=1, raise index, and issue a step at the same time -> uo_out=0, step=0.
REQ-040 Hold A=B=1 through reset release -> no err and no count; then 11->10 -> uo_out=1.
REQ-041 With QDEC_GLITCH_FILTER_EN defined, apply a 2-cycle A glitch -> uo_out unchanged; a 3-cycle-stable change -> a count after edge k+4.
